pic_frame_capture: RTL and testbench
====================================

// Module: pic_frame_capture
// PURPOSE
//  Receiving end of the pixel stream protocol (valid-qualified 16-bit pixels, 784 per 28x28 frame).
//  Captures one frame into an internal frame buffer and tracks row/column position.
//  Flags frame completion, then serves random-access reads to downstream conv/compare logic.
//  Sits between the picture source and the first compute layer; also used as a test-bench frame sink.
// PARAMETERS
//  DATA_W   16   pixel width
//  IMG_W    28   pixels per row
//  IMG_H    28   rows per frame
//  ADDR_W   10   buffer address width; 2**ADDR_W >= IMG_W*IMG_H
// PORTS
//  clk            in   1       clock; all logic on posedge
//  rst_n          in   1       reset: synchronous, active-low
//  cap_start      in   1       1-cycle pulse: arm/restart capture of a new frame
//  pic_in_valid   in   1       pixel qualifier; one pixel accepted per valid cycle, no backpressure
//  data_pic_in    in   DATA_W  pixel data, sampled when pic_in_valid=1
//  rd_en          in   1       read request
//  rd_addr        in   ADDR_W  linear pixel address, row*IMG_W+col
//  rd_data        out  DATA_W  read data, 1 cycle after rd_en
//  rd_valid       out  1       1-cycle pulse aligned with rd_data
//  busy           out  1       1 while in CAPTURE
//  frame_ready    out  1       level: complete frame held in buffer
//  frame_done     out  1       1-cycle pulse on completion
//  row_idx        out  5       row of the next pixel to be written
//  col_idx        out  5       column of the next pixel to be written
//  err_overrun    out  1       sticky: pixel arrived while not capturing
//  checksum       out  32      frame checksum (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE; all outputs 0; wr_ptr, row and col 0. Buffer contents undefined.
//  FSM states: IDLE, CAPTURE, READY.
//   IDLE    : cap_start -> CAPTURE.
//   CAPTURE : cap_start -> restart CAPTURE with pointers at 0. No frame_done.
//             Write of pixel IMG_W*IMG_H-1 (783) -> READY.
//   READY   : cap_start -> CAPTURE. frame_ready drops the cycle after cap_start.
//  Entering CAPTURE: wr_ptr, row, col and checksum are cleared. err_overrun is cleared.
//  Accepted pixel (CAPTURE & pic_in_valid & !cap_start):
//   - written at wr_ptr; wr_ptr is incremented.
//   - col increments; at col=IMG_W-1, col wraps to 0 and row increments.
//  Last-pixel write cycle: the next cycle shows state=READY, frame_ready=1, frame_done=1 for 1 cycle,
//   busy=0, row=IMG_H, col=0.
//  pic_in_valid in IDLE/READY: pixel is dropped and err_overrun is set.
//   In READY the stored frame is never modified.
//  pic_in_valid in the same cycle as cap_start: pixel is dropped and not flagged.
//  Reads are allowed in any state. Latency is 1 cycle.
//   Read/write to the same address in one cycle returns the old data (read-first).
//   rd_addr >= IMG_W*IMG_H: rd_data=0 and rd_valid=1.
//  Reset mid-capture: returns to IDLE; any partial frame is discarded (frame_ready=0).
// CONFIGURATION
//  PIC_CHECKSUM_EN defined:
//   - checksum = 32-bit wrapping sum of accepted pixels, zero-extended.
//   - cleared on entry to CAPTURE; frozen in READY.
//  PIC_CHECKSUM_EN undefined: checksum port present, tied to 0, no adder logic.
// STRUCTURE
//  Shared package pic_pkg:
//   - IMG_W, IMG_H, PIC_PIXELS=784, DATA_W.
//   - state enum {ST_IDLE, ST_CAPTURE, ST_READY}.
//  Sub-module pic_frame_ram: simple dual-port RAM, 1 write port + 1 synchronous read-first read port,
//   BRAM-inferable, depth PIC_PIXELS.
//  pic_frame_capture holds the FSM, pointers, flags, read-range check and optional checksum.
// TESTING
//  1 cap_start, then 784 consecutive valid pixels with value=index.
//    -> frame_done pulses 1 cycle after the 784th pixel; rd_addr 0/27/28/783 return 0/27/28/783.
//  2 Valid held at 50% duty (alternate cycles).
//    -> wr_ptr advances only on valid; row_idx=1/col_idx=0 after 28 accepted pixels; frame_done after 784th.
//  3 Valid pixels while IDLE, then while READY.
//    -> err_overrun=1; rd_addr 5 still returns the frame-1 value; next cap_start clears err_overrun.
//  4 cap_start after 400 pixels, then 784 pixels with value 0xA000+index.
//    -> no frame_done until the 784th new pixel; rd_addr 399 returns 0xA18F.
//  5 rst_n=0 for 1 cycle at pixel 300 -> all outputs 0, state IDLE; rd_addr=800 -> rd_data=0, rd_valid=1.
//  6 PIC_CHECKSUM_EN, pixels all 0xFFFF -> checksum = 784*65535 = 0x030FFCF0 in READY; macro off -> 0.

Source files
------------

// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared frame geometry, widths and capture state type
package pic_pkg;

  localparam int DATA_W     = 16;
  localparam int IMG_W      = 28;
  localparam int IMG_H      = 28;
  localparam int ADDR_W     = 10;
  localparam int PIC_PIXELS = IMG_W * IMG_H;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_READY
  } pic_state_e;

endpackage

// File: rtl/pic_frame_ram.sv
// rtl/pic_frame_ram.sv - simple dual-port frame buffer, one write port and one read-first synchronous read port
module pic_frame_ram #(
  parameter int WIDTH = pic_pkg::DATA_W,
  parameter int AW    = pic_pkg::ADDR_W,
  parameter int DEPTH = pic_pkg::PIC_PIXELS
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Both accesses use non-blocking updates, so a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/pic_frame_capture.sv
// rtl/pic_frame_capture.sv - captures one 28x28 pixel frame and serves random-access reads
// Optional PIC_CHECKSUM_EN adds a wrapping 32-bit sum of accepted pixels on the checksum port.
module pic_frame_capture
  import pic_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_start,
  input  logic              pic_in_valid,
  input  logic [DATA_W-1:0] data_pic_in,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              frame_ready,
  output logic              frame_done,
  output logic [4:0]        row_idx,
  output logic [4:0]        col_idx,
  output logic              err_overrun,
  output logic [31:0]       checksum
);

  localparam logic [4:0]        COL_LAST = 5'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(PIC_PIXELS - 1);

  pic_state_e        state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [4:0]        row_q;
  logic [4:0]        col_q;
  logic              busy_q;
  logic              frame_ready_q;
  logic              frame_done_q;
  logic              err_q;
  logic              rd_valid_q;
  logic              rd_hit_q;
  logic              accept;
  logic              rd_in_range;
  logic [DATA_W-1:0] ram_rdata;

  // A pixel coinciding with cap_start belongs to neither frame and is silently dropped.
  assign accept      = (state_q == ST_CAPTURE) && pic_in_valid && !cap_start;
  assign rd_in_range = 32'(rd_addr) < 32'(PIC_PIXELS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      row_q         <= '0;
      col_q         <= '0;
      busy_q        <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (cap_start) begin
        state_q       <= ST_CAPTURE;
        wr_ptr_q      <= '0;
        row_q         <= '0;
        col_q         <= '0;
        busy_q        <= 1'b1;
        frame_ready_q <= 1'b0;
        err_q         <= 1'b0;
      end else begin
        case (state_q)
          ST_CAPTURE: begin
            if (pic_in_valid) begin
              wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
              if (col_q == COL_LAST) begin
                col_q <= '0;
                row_q <= row_q + 5'd1;
              end else begin
                col_q <= col_q + 5'd1;
              end
              if (wr_ptr_q == PTR_LAST) begin
                state_q       <= ST_READY;
                busy_q        <= 1'b0;
                frame_ready_q <= 1'b1;
                frame_done_q  <= 1'b1;
              end
            end
          end
          default: begin
            if (pic_in_valid) begin
              err_q <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  pic_frame_ram #(
    .WIDTH(DATA_W),
    .AW   (ADDR_W),
    .DEPTH(PIC_PIXELS)
  ) u_ram (
    .clk    (clk),
    .wr_en  (accept),
    .wr_addr(wr_ptr_q),
    .wr_data(data_pic_in),
    .rd_en  (rd_en && rd_in_range),
    .rd_addr(rd_addr),
    .rd_data(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      rd_hit_q   <= rd_en && rd_in_range;
    end
  end

  // Out-of-range reads and the idle read port both present zero.
  assign rd_data = rd_hit_q ? ram_rdata : '0;

`ifdef PIC_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else if (cap_start) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= checksum_q + 32'(data_pic_in);
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  assign rd_valid    = rd_valid_q;
  assign busy        = busy_q;
  assign frame_ready = frame_ready_q;
  assign frame_done  = frame_done_q;
  assign row_idx     = row_q;
  assign col_idx     = col_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_pic_frame_capture.sv
// tb/tb_pic_frame_capture.sv - randomized self-checking bench for pic_frame_capture
module tb_pic_frame_capture;

  localparam int NPIX = 784;
  localparam int W    = 28;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cap_start;
  logic        pic_in_valid;
  logic [15:0] data_pic_in;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        frame_ready;
  logic        frame_done;
  logic [4:0]  row_idx;
  logic [4:0]  col_idx;
  logic        err_overrun;
  logic [31:0] checksum;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] ref_mem [NPIX];
  logic [31:0] ref_sum;
  int          ref_count;

  always #5 clk = ~clk;

  pic_frame_capture dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cap_start   (cap_start),
    .pic_in_valid(pic_in_valid),
    .data_pic_in (data_pic_in),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .busy        (busy),
    .frame_ready (frame_ready),
    .frame_done  (frame_done),
    .row_idx     (row_idx),
    .col_idx     (col_idx),
    .err_overrun (err_overrun),
    .checksum    (checksum)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_checksum();
`ifdef PIC_CHECKSUM_EN
    return ref_sum;
`else
    return 32'd0;
`endif
  endfunction

  task automatic start_capture();
    cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
    ref_count = 0;
    ref_sum   = 32'd0;
  endtask

  task automatic push(input logic [15:0] d);
    pic_in_valid = 1'b1;
    data_pic_in  = d;
    tick();
    pic_in_valid = 1'b0;
    ref_mem[ref_count] = d;
    ref_sum = ref_sum + 32'(d);
    ref_count++;
  endtask

  // mode 0: base+index, mode 1: random, mode 2: constant base
  task automatic run_pixels(input int n, input int mode, input logic [15:0] base, output int early);
    early = 0;
    for (int i = 0; i < n; i++) begin
      logic [15:0] d;
      case (mode)
        0:       d = base + 16'(ref_count);
        1:       d = 16'($urandom);
        default: d = base;
      endcase
      push(d);
      if (frame_done && ref_count < NPIX) early++;
    end
  endtask

  task automatic rd(input logic [9:0] a, output logic [15:0] d, output logic v);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    d = rd_data;
    v = rd_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cap_start = 1'b0; pic_in_valid = 1'b0; data_pic_in = '0;
    rd_en = 1'b0; rd_addr = '0;
    tick(); tick();
    n_cmp++;
    if ({busy, frame_ready, frame_done, err_overrun, rd_valid, row_idx, col_idx, rd_data, checksum} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b rdy=%b done=%b err=%b rv=%b row=%0d col=%0d rd=%h cs=%h required all zero",
               busy, frame_ready, frame_done, err_overrun, rd_valid, row_idx, col_idx, rd_data, checksum);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_frame();
    int early;
    logic [15:0] d;
    logic v;
    logic [9:0] addrs [4];
    start_capture();
    n_cmp++;
    if ({busy, frame_ready, row_idx, col_idx} !== {1'b1, 1'b0, 5'd0, 5'd0}) begin
      n_bad++;
      $display("FAIL full_start: got busy=%b rdy=%b row=%0d col=%0d required 1 0 0 0", busy, frame_ready, row_idx, col_idx);
    end
    run_pixels(NPIX, 0, 16'd0, early);
    n_cmp++;
    if (early !== 0) begin
      n_bad++; $display("FAIL full_early_done: got %0d early pulses required 0", early);
    end
    n_cmp++;
    if ({frame_done, frame_ready, busy, row_idx, col_idx} !== {1'b1, 1'b1, 1'b0, 5'd28, 5'd0}) begin
      n_bad++;
      $display("FAIL full_complete: got done=%b rdy=%b busy=%b row=%0d col=%0d required 1 1 0 28 0",
               frame_done, frame_ready, busy, row_idx, col_idx);
    end
    n_cmp++;
    if (checksum !== exp_checksum()) begin
      n_bad++; $display("FAIL full_checksum: got %h required %h", checksum, exp_checksum());
    end
    tick();
    n_cmp++;
    if ({frame_done, frame_ready} !== 2'b01) begin
      n_bad++; $display("FAIL full_done_pulse: got done=%b rdy=%b required 0 1", frame_done, frame_ready);
    end
    addrs[0] = 10'd0; addrs[1] = 10'd27; addrs[2] = 10'd28; addrs[3] = 10'd783;
    for (int i = 0; i < 4; i++) begin
      rd(addrs[i], d, v);
      n_cmp++;
      if ({v, d} !== {1'b1, 16'(addrs[i])}) begin
        n_bad++; $display("FAIL full_read[%0d]: got v=%b d=%h required 1 %h", addrs[i], v, d, 16'(addrs[i]));
      end
    end
  endtask

  task automatic test_half_duty();
    int early = 0;
    logic [15:0] d;
    logic v;
    start_capture();
    for (int cyc = 0; ref_count < NPIX && cyc < 4000; cyc++) begin
      if (cyc % 2 == 0) begin
        push(16'($urandom));
        if (frame_done && ref_count < NPIX) early++;
      end else begin
        tick();
        n_cmp++;
        if ({row_idx, col_idx} !== {5'(ref_count / W), 5'(ref_count % W)}) begin
          n_bad++;
          $display("FAIL half_position@%0d: got row=%0d col=%0d required %0d %0d",
                   ref_count, row_idx, col_idx, ref_count / W, ref_count % W);
        end
        if (ref_count == W) begin
          n_cmp++;
          if ({row_idx, col_idx} !== {5'd1, 5'd0}) begin
            n_bad++; $display("FAIL half_row_wrap: got row=%0d col=%0d required 1 0", row_idx, col_idx);
          end
        end
      end
    end
    n_cmp++;
    if ({early, ref_count} !== {32'd0, 32'(NPIX)}) begin
      n_bad++; $display("FAIL half_progress: got early=%0d accepted=%0d required 0 %0d", early, ref_count, NPIX);
    end
    n_cmp++;
    if ({frame_done, frame_ready, checksum} !== {1'b1, 1'b1, exp_checksum()}) begin
      n_bad++; $display("FAIL half_complete: got done=%b rdy=%b cs=%h required 1 1 %h", frame_done, frame_ready, checksum, exp_checksum());
    end
    for (int i = 0; i < 16; i++) begin
      logic [9:0] a;
      a = 10'($urandom_range(NPIX - 1));
      rd(a, d, v);
      n_cmp++;
      if ({v, d} !== {1'b1, ref_mem[a]}) begin
        n_bad++; $display("FAIL half_read[%0d]: got v=%b d=%h required 1 %h", a, v, d, ref_mem[a]);
      end
    end
  endtask

  task automatic test_overrun();
    int early;
    logic [15:0] d;
    logic v;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pic_in_valid = 1'b1; data_pic_in = 16'($urandom); tick();
    end
    pic_in_valid = 1'b0;
    n_cmp++;
    if ({err_overrun, frame_ready, busy} !== 3'b100) begin
      n_bad++; $display("FAIL overrun_idle: got err=%b rdy=%b busy=%b required 1 0 0", err_overrun, frame_ready, busy);
    end
    start_capture();
    n_cmp++;
    if (err_overrun !== 1'b0) begin
      n_bad++; $display("FAIL overrun_clear1: got %b required 0", err_overrun);
    end
    run_pixels(NPIX, 0, 16'd0, early);
    for (int i = 0; i < 5; i++) begin
      pic_in_valid = 1'b1; data_pic_in = 16'hDEAD; tick();
    end
    pic_in_valid = 1'b0;
    n_cmp++;
    if ({err_overrun, frame_ready, row_idx, col_idx, checksum} !== {1'b1, 1'b1, 5'd28, 5'd0, exp_checksum()}) begin
      n_bad++;
      $display("FAIL overrun_ready: got err=%b rdy=%b row=%0d col=%0d cs=%h required 1 1 28 0 %h",
               err_overrun, frame_ready, row_idx, col_idx, checksum, exp_checksum());
    end
    rd(10'd5, d, v);
    n_cmp++;
    if ({v, d} !== {1'b1, 16'd5}) begin
      n_bad++; $display("FAIL overrun_read5: got v=%b d=%h required 1 0005", v, d);
    end
    for (int a = 0; a < NPIX; a++) begin
      rd(10'(a), d, v);
      n_cmp++;
      if ({v, d} !== {1'b1, ref_mem[a]}) begin
        n_bad++; $display("FAIL overrun_frame[%0d]: got v=%b d=%h required 1 %h", a, v, d, ref_mem[a]);
      end
    end
    start_capture();
    n_cmp++;
    if ({err_overrun, frame_ready, busy} !== 3'b001) begin
      n_bad++; $display("FAIL overrun_clear2: got err=%b rdy=%b busy=%b required 0 0 1", err_overrun, frame_ready, busy);
    end
  endtask

  task automatic test_restart();
    int early;
    logic [15:0] d;
    logic v;
    start_capture();
    run_pixels(400, 1, 16'd0, early);
    cap_start = 1'b1; pic_in_valid = 1'b1; data_pic_in = 16'h1234;
    tick();
    cap_start = 1'b0; pic_in_valid = 1'b0;
    ref_count = 0; ref_sum = 32'd0;
    n_cmp++;
    if ({err_overrun, busy, frame_ready, row_idx, col_idx} !== {1'b0, 1'b1, 1'b0, 5'd0, 5'd0}) begin
      n_bad++;
      $display("FAIL restart_state: got err=%b busy=%b rdy=%b row=%0d col=%0d required 0 1 0 0 0",
               err_overrun, busy, frame_ready, row_idx, col_idx);
    end
    run_pixels(NPIX, 0, 16'hA000, early);
    n_cmp++;
    if ({early, 31'd0, frame_done} !== {32'd0, 31'd0, 1'b1}) begin
      n_bad++; $display("FAIL restart_done: got early=%0d done=%b required 0 1", early, frame_done);
    end
    n_cmp++;
    if (checksum !== exp_checksum()) begin
      n_bad++; $display("FAIL restart_checksum: got %h required %h", checksum, exp_checksum());
    end
    rd(10'd399, d, v);
    n_cmp++;
    if ({v, d} !== {1'b1, 16'hA18F}) begin
      n_bad++; $display("FAIL restart_read399: got v=%b d=%h required 1 a18f", v, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] nd;
    start_capture();
    for (int i = 0; i < NPIX; i++) begin
      nd = 16'($urandom);
      pic_in_valid = 1'b1; data_pic_in = nd;
      rd_en = 1'b1; rd_addr = 10'(i);
      tick();
      n_cmp++;
      if ({rd_valid, rd_data} !== {1'b1, ref_mem[i]}) begin
        n_bad++; $display("FAIL rfirst[%0d]: got v=%b d=%h required 1 %h", i, rd_valid, rd_data, ref_mem[i]);
      end
      ref_mem[i] = nd;
    end
    pic_in_valid = 1'b0; rd_en = 1'b0;
    n_cmp++;
    if ({frame_done, frame_ready} !== 2'b11) begin
      n_bad++; $display("FAIL b2b_done: got done=%b rdy=%b required 1 1", frame_done, frame_ready);
    end
    start_capture();
    n_cmp++;
    if ({frame_done, frame_ready, busy} !== 3'b001) begin
      n_bad++; $display("FAIL b2b_restart: got done=%b rdy=%b busy=%b required 0 0 1", frame_done, frame_ready, busy);
    end
  endtask

  task automatic test_reset_mid();
    int early;
    logic [15:0] d;
    logic v;
    start_capture();
    run_pixels(300, 1, 16'd0, early);
    rst_n = 1'b0; pic_in_valid = 1'b1; data_pic_in = 16'h5555;
    tick();
    rst_n = 1'b1; pic_in_valid = 1'b0;
    n_cmp++;
    if ({busy, frame_ready, frame_done, err_overrun, rd_valid, row_idx, col_idx, rd_data, checksum} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got busy=%b rdy=%b done=%b err=%b rv=%b row=%0d col=%0d rd=%h cs=%h required all zero",
               busy, frame_ready, frame_done, err_overrun, rd_valid, row_idx, col_idx, rd_data, checksum);
    end
    rd(10'd800, d, v);
    n_cmp++;
    if ({v, d} !== {1'b1, 16'd0}) begin
      n_bad++; $display("FAIL oor_read800: got v=%b d=%h required 1 0000", v, d);
    end
    rd(10'd1023, d, v);
    n_cmp++;
    if ({v, d} !== {1'b1, 16'd0}) begin
      n_bad++; $display("FAIL oor_read1023: got v=%b d=%h required 1 0000", v, d);
    end
    tick();
    n_cmp++;
    if ({rd_valid, frame_ready, busy} !== 3'b000) begin
      n_bad++; $display("FAIL midreset_idle: got rv=%b rdy=%b busy=%b required 0 0 0", rd_valid, frame_ready, busy);
    end
  endtask

  task automatic test_checksum();
    int early;
    logic [31:0] exp_cs;
`ifdef PIC_CHECKSUM_EN
    exp_cs = 32'h030FFCF0;
`else
    exp_cs = 32'd0;
`endif
    start_capture();
    run_pixels(NPIX, 2, 16'hFFFF, early);
    n_cmp++;
    if ({frame_ready, checksum} !== {1'b1, exp_cs}) begin
      n_bad++; $display("FAIL checksum_ffff: got rdy=%b cs=%h required 1 %h", frame_ready, checksum, exp_cs);
    end
    for (int i = 0; i < 4; i++) begin
      pic_in_valid = 1'b1; data_pic_in = 16'($urandom); tick();
    end
    pic_in_valid = 1'b0;
    n_cmp++;
    if (checksum !== exp_cs) begin
      n_bad++; $display("FAIL checksum_frozen: got %h required %h", checksum, exp_cs);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_half_duty();
    test_overrun();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    test_checksum();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
